// File: rtl/l2_tlb_banked.sv
// Banked L2 TLB: ENTRIES entries held as ROWS rows of BANKS, scanned one row per cycle.
// Lookups stop on the first hitting row; ASID/global invalidation sweeps row by row.
module l2_tlb_banked #(
   parameter int ENTRIES = 64,
   parameter int BANKS   = 8,
   parameter int IDX_W   = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      cp0_entryhi,
   input  logic [31:0]      cp0_entrylo0,
   input  logic [31:0]      cp0_entrylo1,
   input  logic [31:0]      cp0_pagemask,
   input  logic [IDX_W-1:0] cp0_index,
   input  logic [IDX_W-1:0] cp0_random,
   input  logic             qry_valid,
   output logic             qry_ready,
   input  logic [31:0]      qry_vaddr,
   input  logic             qry_useentryhi,
   output logic             resp_valid,
   output logic             resp_hit,
   output logic [IDX_W-1:0] resp_index,
   output logic [89:0]      resp_entry,
   output logic [89:0]      rd_entry,
   output logic             rd_live,
   input  logic             tlbwi_en,
   input  logic             tlbwr_en,
   input  logic             inv_en,
   input  logic             inv_all,
   output logic             busy
);

   localparam int ROWS = ENTRIES / BANKS;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP, S_INV} state_t;

   logic [89:0]        r_ent [ENTRIES];
   logic [ENTRIES-1:0] r_live;
   state_t             r_state;
   logic [RW-1:0]      r_row;
   logic [18:0]        r_qvpn;
   logic [7:0]         r_qasid;
   logic               r_inv_all;
   logic [7:0]         r_inv_asid;
   logic               r_resp_valid;
   logic               r_resp_hit;
   logic [IDX_W-1:0]   r_resp_index;
   logic [89:0]        r_resp_entry;
   logic [89:0]        r_rd_entry;
   logic               r_rd_live;

   logic               w_we;
   logic [IDX_W-1:0]   w_widx;
   logic [89:0]        w_wdata;
   logic [IDX_W-1:0]   w_bidx [BANKS];
   logic [BANKS-1:0]   w_bhit;
   logic [BANKS-1:0]   w_binv;
   logic               w_hit;
   logic [IDX_W-1:0]   w_hidx;
   logic [89:0]        w_hent;
   logic [ENTRIES-1:0] w_live_nxt;
   logic               w_last_row;
   logic               w_unused;

   assign w_unused = ^{qry_vaddr[12:0], cp0_entryhi[12:8], cp0_pagemask[31:25],
                       cp0_pagemask[12:0], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

   assign w_we    = tlbwi_en | tlbwr_en;
   assign w_widx  = tlbwi_en ? cp0_index : cp0_random;
   assign w_wdata = {cp0_entryhi[31:13], cp0_entryhi[7:0], cp0_pagemask[24:13],
                     cp0_entrylo0[0] & cp0_entrylo1[0], cp0_entrylo1[25:1], cp0_entrylo0[25:1]};

   assign w_last_row = (r_row == RW'(ROWS - 1));

   always_comb begin
      for (int unsigned b = 0; b < BANKS; b++) begin
         w_bidx[b] = IDX_W'(32'(r_row) * BANKS + b);
      end
   end

   always_comb begin
      w_bhit = '0;
      w_binv = '0;
      w_hit  = 1'b0;
      w_hidx = '0;
      w_hent = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         w_bhit[b] = r_live[w_bidx[b]]
                   & (((r_ent[w_bidx[b]][89:71] ^ r_qvpn) & ~{7'b0, r_ent[w_bidx[b]][62:51]}) == '0)
                   & (r_ent[w_bidx[b]][50] | (r_ent[w_bidx[b]][70:63] == r_qasid));
         w_binv[b] = r_inv_all | (~r_ent[w_bidx[b]][50] & (r_ent[w_bidx[b]][70:63] == r_inv_asid));
         // lowest bank in the row wins
         if (w_bhit[b] && !w_hit) begin
            w_hit  = 1'b1;
            w_hidx = w_bidx[b];
            w_hent = r_ent[w_bidx[b]];
         end
      end
   end

   // A write in the same cycle as the sweep of its row survives the sweep.
   always_comb begin
      w_live_nxt = r_live;
      if (r_state == S_INV) begin
         for (int unsigned b = 0; b < BANKS; b++) begin
            if (w_binv[b]) w_live_nxt[w_bidx[b]] = 1'b0;
         end
      end
      if (w_we) w_live_nxt[w_widx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_we) r_ent[w_widx] <= w_wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_live     <= '0;
         r_rd_entry <= '0;
         r_rd_live  <= 1'b0;
      end else begin
         r_live     <= w_live_nxt;
         r_rd_entry <= (w_we && (w_widx == cp0_index)) ? w_wdata : r_ent[cp0_index];
         r_rd_live  <= w_live_nxt[cp0_index];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_row        <= '0;
         r_qvpn       <= '0;
         r_qasid      <= '0;
         r_inv_all    <= 1'b0;
         r_inv_asid   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_index <= '0;
         r_resp_entry <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_row <= '0;
               if (inv_en) begin
                  r_state    <= S_INV;
                  r_inv_all  <= inv_all;
                  r_inv_asid <= cp0_entryhi[7:0];
               end else if (qry_valid) begin
                  r_state <= S_SCAN;
                  r_qvpn  <= qry_useentryhi ? cp0_entryhi[31:13] : qry_vaddr[31:13];
                  r_qasid <= cp0_entryhi[7:0];
               end
            end
            S_SCAN: begin
               if (w_we) begin
                  r_row <= '0;
               end else if (w_hit || w_last_row) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_hit   <= w_hit;
                  r_resp_index <= w_hidx;
                  r_resp_entry <= w_hent;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end
            S_RESP: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_row        <= '0;
            end
            S_INV: begin
               if (w_last_row) begin
                  r_state <= S_IDLE;
                  r_row   <= '0;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign qry_ready  = ~busy & ~inv_en;
   assign resp_valid = r_resp_valid;
   assign resp_hit   = r_resp_hit;
   assign resp_index = r_resp_index;
   assign resp_entry = r_resp_entry;
   assign rd_entry   = r_rd_entry;
   assign rd_live    = r_rd_live;

endmodule

// File: tb/tb_l2_tlb_banked.sv
// Scoreboard bench for l2_tlb_banked: a reference entry array predicts each response
// (winner = lowest live matching index, latency from its row), a negedge monitor checks it.
module tb_l2_tlb_banked;

   localparam int ENTRIES = 64;
   localparam int BANKS   = 8;
   localparam int IDX_W   = 6;
   localparam int ROWS    = ENTRIES / BANKS;

   logic             clk;
   logic             resetn = 1'b1;
   logic [31:0]      cp0_entryhi = '0;
   logic [31:0]      cp0_entrylo0 = '0;
   logic [31:0]      cp0_entrylo1 = '0;
   logic [31:0]      cp0_pagemask = '0;
   logic [IDX_W-1:0] cp0_index = '0;
   logic [IDX_W-1:0] cp0_random = '0;
   logic             qry_valid = 1'b0;
   logic             qry_ready;
   logic [31:0]      qry_vaddr = '0;
   logic             qry_useentryhi = 1'b0;
   logic             resp_valid;
   logic             resp_hit;
   logic [IDX_W-1:0] resp_index;
   logic [89:0]      resp_entry;
   logic [89:0]      rd_entry;
   logic             rd_live;
   logic             tlbwi_en = 1'b0;
   logic             tlbwr_en = 1'b0;
   logic             inv_en = 1'b0;
   logic             inv_all = 1'b0;
   logic             busy;

   l2_tlb_banked #(.ENTRIES(ENTRIES), .BANKS(BANKS), .IDX_W(IDX_W)) dut (
      .clk(clk), .resetn(resetn),
      .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
      .cp0_pagemask(cp0_pagemask), .cp0_index(cp0_index), .cp0_random(cp0_random),
      .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_vaddr(qry_vaddr),
      .qry_useentryhi(qry_useentryhi),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_index(resp_index), .resp_entry(resp_entry),
      .rd_entry(rd_entry), .rd_live(rd_live),
      .tlbwi_en(tlbwi_en), .tlbwr_en(tlbwr_en), .inv_en(inv_en), .inv_all(inv_all), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic             hit;
      logic [IDX_W-1:0] idx;
      logic [89:0]      ent;
      int               at;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [89:0] m_ent  [ENTRIES];
   logic        m_live [ENTRIES];
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [89:0] got, input logic [89:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 90'(resp_valid), 90'(0));
         end else begin
            mon_e = sb.pop_front();
            check("resp_hit", 90'(resp_hit), 90'(mon_e.hit));
            check("resp_index", 90'(resp_index), 90'(mon_e.idx));
            check("resp_entry", resp_entry, mon_e.ent);
            check("resp_cycle", 90'(cyc), 90'(mon_e.at));
         end
      end
   end

   function automatic logic [31:0] mk_lo(input logic [19:0] pfn, input logic g);
      return {6'b0, pfn, 3'd3, 1'b1, 1'b1, g};
   endfunction

   function automatic logic [89:0] mk_ent(input logic [31:0] eh, input logic [31:0] lo0,
                                          input logic [31:0] lo1, input logic [31:0] pm);
      return {eh[31:13], eh[7:0], pm[24:13], lo0[0] & lo1[0], lo1[25:1], lo0[25:1]};
   endfunction

   function automatic logic m_hit(input int i, input logic [18:0] vpn, input logic [7:0] asid);
      logic [89:0] e;
      e = m_ent[i];
      return m_live[i] && (((e[89:71] ^ vpn) & ~{7'b0, e[62:51]}) == 19'd0)
             && (e[50] || (e[70:63] == asid));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // acc: the cycle after which row 0 is compared (acceptance or restarting write)
   task automatic push_exp(input logic [18:0] vpn, input logic [7:0] asid, input int acc);
      exp_t e;
      e.hit = 1'b0;
      e.idx = '0;
      e.ent = '0;
      e.at  = acc + ROWS + 1;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!e.hit && m_hit(i, vpn, asid)) begin
            e.hit = 1'b1;
            e.idx = IDX_W'(i);
            e.ent = m_ent[i];
            e.at  = acc + i / BANKS + 2;
         end
      end
      sb.push_back(e);
   endtask

   // mode 0: TLBWI, 1: TLBWR, 2: both (TLBWI at idx must win over random=idx+1)
   task automatic tlb_write(input int mode, input logic [IDX_W-1:0] idx, input logic [31:0] eh,
                            input logic [19:0] pfn, input logic g, input logic [31:0] pm);
      cp0_entryhi  = eh;
      cp0_entrylo0 = mk_lo(pfn, g);
      cp0_entrylo1 = mk_lo(pfn + 20'h1, g);
      cp0_pagemask = pm;
      if (mode == 0 || mode == 2) begin
         tlbwi_en  = 1'b1;
         cp0_index = idx;
      end
      if (mode == 1) begin
         tlbwr_en   = 1'b1;
         cp0_random = idx;
      end
      if (mode == 2) begin
         tlbwr_en   = 1'b1;
         cp0_random = idx + 1'b1;
      end
      m_ent[idx]  = mk_ent(cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_pagemask);
      m_live[idx] = 1'b1;
      tick();
      tlbwi_en = 1'b0;
      tlbwr_en = 1'b0;
   endtask

   task automatic query(input logic [31:0] vaddr, input logic [31:0] eh, input logic useeh);
      cp0_entryhi    = eh;
      qry_vaddr      = vaddr;
      qry_useentryhi = useeh;
      check("qry_ready_idle", 90'(qry_ready), 90'(1));
      qry_valid = 1'b1;
      push_exp(useeh ? eh[31:13] : vaddr[31:13], eh[7:0], cyc);
      tick();
      qry_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      if (sb.size() != 0) begin
         check("resp_timeout", 90'(sb.size()), 90'(0));
         sb.delete();
      end
      tick();
   endtask

   task automatic rd_chk(input logic [IDX_W-1:0] idx, input logic exp_live, input logic chk_ent);
      cp0_index = idx;
      tick();
      check("rd_live", 90'(rd_live), 90'(exp_live));
      if (chk_ent) check("rd_entry", rd_entry, m_ent[idx]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int w;
      int n;
      for (int i = 0; i < ENTRIES; i++) begin
         m_live[i] = 1'b0;
         m_ent[i]  = '0;
      end
      #2 resetn = 1'b0;
      repeat (3) tick();
      check("rst_resp_valid", 90'(resp_valid), 90'(0));
      check("rst_resp_hit", 90'(resp_hit), 90'(0));
      check("rst_resp_index", 90'(resp_index), 90'(0));
      check("rst_resp_entry", resp_entry, 90'(0));
      check("rst_rd_entry", rd_entry, 90'(0));
      check("rst_rd_live", 90'(rd_live), 90'(0));
      check("rst_busy", 90'(busy), 90'(0));
      resetn = 1'b1;
      tick();

      // empty TLB: full miss at cycle ROWS+1
      query(32'h0040_0000, 32'h0000_0000, 1'b0);
      check("qry_ready_scan", 90'(qry_ready), 90'(0));
      check("busy_scan", 90'(busy), 90'(1));
      drain();

      // single entry in row 1, ASID match and mismatch
      tlb_write(0, 6'd13, 32'h0040_0005, 20'h11110, 1'b0, 32'h0);
      query(32'h0040_1000, 32'h0000_0005, 1'b0);
      drain();
      query(32'h0040_1000, 32'h0000_0006, 1'b0);
      drain();
      rd_chk(6'd13, 1'b1, 1'b1);

      // masked entry in row 0 beats global entry in row 5; then entryhi-sourced lookup
      tlb_write(0, 6'd2, 32'h0040_2005, 20'h22220, 1'b0, 32'h0000_6000);
      tlb_write(1, 6'd40, 32'h0040_4009, 20'h44440, 1'b1, 32'h0);
      query(32'h0040_4000, 32'h0000_0005, 1'b0);
      drain();
      query(32'hFFFF_F000, 32'h0040_4007, 1'b1);
      drain();

      // TLBWI over TLBWR priority
      tlb_write(2, 6'd20, 32'h0042_0006, 20'h20200, 1'b0, 32'h0);
      rd_chk(6'd21, 1'b0, 1'b0);
      rd_chk(6'd20, 1'b1, 1'b1);

      // write during a scan restarts it from row 0
      cp0_entryhi    = 32'h0060_0005;
      qry_vaddr      = 32'h0060_0000;
      qry_useentryhi = 1'b0;
      check("qry_ready_idle", 90'(qry_ready), 90'(1));
      qry_valid = 1'b1;
      a = cyc;
      tick();
      qry_valid = 1'b0;
      repeat (3) tick();
      w = cyc;
      tlb_write(1, 6'd63, 32'h0060_0005, 20'h63630, 1'b0, 32'h0);
      push_exp(19'h00300, 8'd5, w);
      check("restart_expected_at", 90'(sb[0].at), 90'(a + 13));
      drain();

      // ASID 5 invalidate; a simultaneous query must not be accepted
      cp0_entryhi = 32'h0000_0005;
      qry_vaddr   = 32'h0040_4000;
      inv_en      = 1'b1;
      inv_all     = 1'b0;
      qry_valid   = 1'b1;
      #1;
      check("qry_ready_inv", 90'(qry_ready), 90'(0));
      tick();
      inv_en    = 1'b0;
      qry_valid = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!m_ent[i][50] && m_ent[i][70:63] == 8'd5) m_live[i] = 1'b0;
      end
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy) n++;
         tick();
      end
      check("inv_busy_cycles", 90'(n), 90'(ROWS));
      query(32'h0040_4000, 32'h0000_0005, 1'b0);
      drain();
      query(32'h0060_0000, 32'h0000_0005, 1'b0);
      drain();
      query(32'h0040_1000, 32'h0000_0005, 1'b0);
      drain();
      query(32'h0042_0000, 32'h0000_0006, 1'b0);
      drain();
      rd_chk(6'd2, 1'b0, 1'b1);
      rd_chk(6'd13, 1'b0, 1'b1);
      rd_chk(6'd63, 1'b0, 1'b1);
      rd_chk(6'd40, 1'b1, 1'b1);

      // reset in the middle of a hitting scan: no response, all entries dead
      query(32'h0040_4000, 32'h0000_0005, 1'b0);
      repeat (2) tick();
      resetn = 1'b0;
      sb.delete();
      for (int i = 0; i < ENTRIES; i++) m_live[i] = 1'b0;
      #1;
      check("midrst_busy", 90'(busy), 90'(0));
      check("midrst_resp_valid", 90'(resp_valid), 90'(0));
      repeat (8) tick();
      resetn = 1'b1;
      tick();
      check("postrst_qry_ready", 90'(qry_ready), 90'(1));
      rd_chk(6'd40, 1'b0, 1'b0);
      query(32'h0040_4000, 32'h0000_0005, 1'b0);
      drain();
      repeat (12) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
